// File: rtl/stream_sink_pkg.sv
// Shared types and constants for the stream sink checker.
package stream_sink_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sink_state_t;

    typedef enum logic [1:0] {
        STALL_NONE = 2'd0,
        STALL_ALL  = 2'd1,
        STALL_LFSR = 2'd2,
        STALL_ALT  = 2'd3
    } stall_mode_t;

    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // Fibonacci step, polynomial x^16 + x^14 + x^13 + x^11 + 1, shifting toward bit 0.
    function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

endpackage

// File: rtl/stream_sink_checker_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous load; a zero seed is replaced by the default seed.
module lfsr16
    import stream_sink_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        advance,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
        end else if (advance) begin
            state_d = lfsr16_next(state_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LFSR_DEFAULT_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/stream_sink_checker.sv
// Valid/ready stream sink: programmable backpressure, incrementing-sequence data check.
// Define STREAM_SINK_PROTO_CHECK_EN to enable the upstream handshake-protocol monitor.
module stream_sink_checker
    import stream_sink_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] expect_first,
    input  logic [CNT_W-1:0] expect_len,
    input  logic [1:0]       stall_mode,
    input  logic [15:0]      seed,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] xfer_count,
    output logic [CNT_W-1:0] err_count,
    output logic [WIDTH-1:0] err_expected,
    output logic [WIDTH-1:0] err_actual,
    output logic             proto_err
);

    sink_state_t      state_q, state_d;
    stall_mode_t      mode_q, mode_d, mode_sel;
    logic [CNT_W-1:0] len_q, len_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [CNT_W-1:0] xfer_q, xfer_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [WIDTH-1:0] eexp_q, eexp_d;
    logic [WIDTH-1:0] eact_q, eact_d;
    logic             ready_q, ready_d;

    logic             arm;
    logic             hs;
    logic             pat;
    logic             seed_lsb;
    logic [15:0]      lfsr_state;

    lfsr16 u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (arm),
        .seed    (seed),
        .advance (state_q == RUN),
        .state   (lfsr_state)
    );

    assign seed_lsb = (seed == 16'h0000) ? LFSR_DEFAULT_SEED[0] : seed[0];
    assign hs       = (state_q == RUN) && in_valid && ready_q;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        len_d   = len_q;
        exp_d   = exp_q;
        xfer_d  = xfer_q;
        err_d   = err_q;
        eexp_d  = eexp_q;
        eact_d  = eact_q;
        arm     = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    arm     = 1'b1;
                    state_d = RUN;
                    mode_d  = stall_mode_t'(stall_mode);
                    len_d   = expect_len;
                    exp_d   = expect_first;
                    xfer_d  = '0;
                    err_d   = '0;
                    eexp_d  = '0;
                    eact_d  = '0;
                end
            end
            RUN: begin
                if (hs) begin
                    xfer_d = xfer_q + CNT_W'(1);
                    if (in_data != exp_q) begin
                        if (err_q != '1) begin
                            err_d = err_q + CNT_W'(1);
                        end
                        if (err_q == '0) begin
                            eexp_d = exp_q;
                            eact_d = in_data;
                        end
                    end
                    exp_d = exp_q + WIDTH'(1);
                    if ((len_q != '0) && (xfer_d == len_q)) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Ready is registered, so the pattern is evaluated for the cycle being entered:
        // on arm that is the freshly loaded seed, otherwise the LFSR's next value.
        mode_sel = arm ? stall_mode_t'(stall_mode) : mode_q;
        case (mode_sel)
            STALL_NONE: pat = 1'b1;
            STALL_ALL:  pat = 1'b0;
            STALL_LFSR: pat = arm ? seed_lsb : 1'(lfsr16_next(lfsr_state));
            STALL_ALT:  pat = arm ? 1'b1 : !ready_q;
            default:    pat = 1'b0;
        endcase

        ready_d = (state_d == RUN) && pat;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= STALL_NONE;
            len_q   <= '0;
            exp_q   <= '0;
            xfer_q  <= '0;
            err_q   <= '0;
            eexp_q  <= '0;
            eact_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            exp_q   <= exp_d;
            xfer_q  <= xfer_d;
            err_q   <= err_d;
            eexp_q  <= eexp_d;
            eact_q  <= eact_d;
            ready_q <= ready_d;
        end
    end

`ifdef STREAM_SINK_PROTO_CHECK_EN
    logic             stalled_q;
    logic [WIDTH-1:0] held_q;
    logic             proto_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stalled_q <= 1'b0;
            held_q    <= '0;
            proto_q   <= 1'b0;
        end else begin
            stalled_q <= in_valid && !ready_q;
            held_q    <= in_data;
            if (arm) begin
                proto_q <= 1'b0;
            end else if ((state_q == RUN) && stalled_q && (!in_valid || (in_data != held_q))) begin
                proto_q <= 1'b1;
            end
        end
    end

    assign proto_err = proto_q;
`else
    assign proto_err = 1'b0;
`endif

    assign in_ready     = ready_q;
    assign busy         = (state_q == RUN);
    assign done         = (state_q == DONE);
    assign xfer_count   = xfer_q;
    assign err_count    = err_q;
    assign err_expected = eexp_q;
    assign err_actual   = eact_q;

endmodule

// File: doc/stream_sink_checker.md
Name: stream_sink_checker

Overview:
- Consumer end of the team's valid/ready streaming interface; sits downstream of pipeline/skid stages in block and system benches, and in on-chip BIST.
- Drives in_ready with a programmable backpressure pattern and checks incoming data against an incrementing expected sequence.
- Counts transfers and mismatches, and optionally flags upstream handshake-protocol violations.
- Fully synthesizable. No SV assertions are required for function.

Parameters:
- WIDTH, 32, data width in bits.
- CNT_W, 16, width of the length, transfer-count and error-count fields.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  single-cycle arm pulse; honoured only in IDLE or DONE.
- expect_first  input  WIDTH  first expected data word, sampled on start.
- expect_len  input  CNT_W  number of transfers to accept, sampled on start; 0 = unlimited.
- stall_mode  input  2  backpressure mode, sampled on start: 0 always ready, 1 never ready, 2 LFSR, 3 alternate.
- seed  input  16  LFSR seed, sampled on start; 0 is replaced by 16'hACE1.
- in_valid  input  1  upstream valid.
- in_ready  output  1  registered ready.
- in_data  input  WIDTH  upstream data.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- xfer_count  output  CNT_W  accepted transfers since start.
- err_count  output  CNT_W  data mismatches; saturates at all-ones.
- err_expected  output  WIDTH  expected value at the first mismatch.
- err_actual  output  WIDTH  received value at the first mismatch.
- proto_err  output  1  sticky protocol-violation flag.

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous, active-low.
- Reset values: state IDLE; all outputs 0; LFSR 16'hACE1; expected register 0.
- Handshake: a transfer occurs on a rising edge where in_valid && in_ready.
- FSM IDLE -> RUN: on start. Latch config, set expected = expect_first, clear xfer_count, err_count, err_expected, err_actual and proto_err, load the LFSR.
- FSM RUN -> DONE: when the accepted transfer makes xfer_count == expect_len (expect_len != 0).
- FSM DONE -> RUN: on start, with the same re-arm as from IDLE.
- start in RUN is ignored.
- in_ready is registered; next value = (next state == RUN) && pattern.
  - First possible ready is the cycle after start.
  - in_ready falls in the cycle after the final handshake; no extra transfer is accepted.
- Patterns:
  - Mode 0: ready = 1.
  - Mode 1: ready = 0.
  - Mode 2: ready = lfsr[0]. LFSR is 16-bit Fibonacci, taps 16,14,13,11, advancing every RUN cycle.
  - Mode 3: ready toggles every cycle, high in the first RUN cycle.
- Each transfer:
  - xfer_count += 1.
  - If in_data != expected: err_count += 1 (saturating). On the first mismatch only, capture err_expected and err_actual.
  - expected += 1, modulo 2^WIDTH; wraps all-ones -> 0. expected always follows the sequence, not the received data.
- CNT_W overflow with expect_len = 0: xfer_count wraps and the block stays in RUN.
- A reset asserted mid-run returns the block to IDLE on that edge; nothing is retained.
- in_valid in IDLE or DONE is never accepted (in_ready = 0).

Optional Feature:
- Macro STREAM_SINK_PROTO_CHECK_EN.
- When defined:
  - Register stalled = in_valid && !in_ready and the held data each cycle.
  - In RUN, if the previous cycle was stalled and now in_valid == 0, or in_data differs from the held data, set proto_err. It stays set until start or reset.
- When undefined: proto_err is tied to 0 and no check registers exist.

Decomposition:
- Package stream_sink_pkg holds:
  - enum sink_state_t {IDLE, RUN, DONE};
  - enum stall_mode_t {STALL_NONE=0, STALL_ALL=1, STALL_LFSR=2, STALL_ALT=3};
  - constant LFSR_DEFAULT_SEED = 16'hACE1.
- One sub-module is natural: lfsr16, with ports clk, rst_n, load, seed, advance and the 16-bit state. The checker instantiates it.

Test Plan:
- Mode 0, expect_first=10, expect_len=5, upstream drives 10..14 back-to-back:
  - xfer_count=5, err_count=0.
  - done=1 and in_ready=0 in the cycle after the 5th handshake.
- Mode 0, len=4, upstream drives 10,11,99,13:
  - err_count=1, err_expected=12, err_actual=99.
  - The 4th word, 13, is still accepted as correct.
- Mode 1 with in_valid=1 and data 0xDEADBEEF held 5 cycles, then valid dropped (macro defined):
  - xfer_count=0 and proto_err=1.
  - Repeat with data changed to 0xDEADBEF0 while stalled -> proto_err=1.
- Mode 2, seed=0x1234, len=50, upstream valid random:
  - Exactly 50 transfers, err_count=0.
  - in_ready matches the reference LFSR model cycle by cycle.
- Mode 3, expect_first=32'hFFFFFFFF, len=3, data FFFFFFFF,0,1:
  - in_ready alternates 1,0,1,...
  - err_count=0 across the wrap; done after 3 transfers.
- Reset mid-run after 2 of 5 transfers:
  - All outputs 0 and in_ready=0 on the next edge.
  - A subsequent start re-runs cleanly to xfer_count=5.
